// File: rtl/cache_ctrl_pkg.sv
// Shared types and address helpers for the requester-side cache fill controller.
package cache_ctrl_pkg;

    localparam int IDX_BITS_DEF   = 2;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int TAG_BITS_DEF   = ADDR_WIDTH_DEF - IDX_BITS_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        RESPOND
    } fsm_state_t;

    function automatic logic [TAG_BITS_DEF-1:0] get_tag(
        input logic [ADDR_WIDTH_DEF-1:0] addr
    );
        return addr[ADDR_WIDTH_DEF-1:IDX_BITS_DEF];
    endfunction

    function automatic logic [IDX_BITS_DEF-1:0] get_idx(
        input logic [ADDR_WIDTH_DEF-1:0] addr
    );
        return addr[IDX_BITS_DEF-1:0];
    endfunction

endpackage

// File: rtl/cache_fill_ctrl.sv
// Single-outstanding read controller: looks up cache port A, fetches and
// fills from backing memory on a miss, then returns the word.
module cache_fill_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int IDX_BITS   = IDX_BITS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [ADDR_WIDTH-1:0] cache_addra_o,
    output logic                  cache_cea_o,
    output logic                  cache_we_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    input  logic [DATA_WIDTH-1:0] cache_rdataa_i,
    input  logic                  cache_rhita_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);

    fsm_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  hit_q, hit_d;
    logic [CNT_WIDTH-1:0]  miss_q, miss_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [ADDR_WIDTH-1:0] cache_addra_q, cache_addra_d;
    logic                  cache_cea_q, cache_cea_d;
    logic                  cache_we_q, cache_we_d;
    logic [DATA_WIDTH-1:0] cache_wdata_q, cache_wdata_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;

    // The cache indexes on the low bits and compares the rest as tag.
    logic [ADDR_WIDTH-1:0] line_addr;
    assign line_addr = {addr_d[ADDR_WIDTH-1:IDX_BITS], addr_d[IDX_BITS-1:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hit_d   = hit_q;
        miss_d  = miss_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_rhita_i) begin
                    data_d  = cache_rdataa_i;
                    hit_d   = hit_q + CNT_WIDTH'(1);
                    state_d = RESPOND;
                end else begin
                    miss_d  = miss_q + CNT_WIDTH'(1);
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (mem_resp_valid_i) begin
                    data_d  = mem_resp_data_i;
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = RESPOND;
            end
            RESPOND: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop.
        req_ready_d     = (state_d == IDLE);
        cache_cea_d     = (state_d == LOOKUP) || (state_d == FILL);
        cache_we_d      = (state_d == FILL);
        cache_addra_d   = cache_cea_d ? line_addr : '0;
        cache_wdata_d   = cache_we_d ? data_d : '0;
        mem_req_valid_d = (state_d == MISS_REQ);
        mem_req_addr_d  = mem_req_valid_d ? addr_d : '0;
        resp_valid_d    = (state_d == RESPOND);
        resp_data_d     = resp_valid_d ? data_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            hit_q           <= '0;
            miss_q          <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            cache_addra_q   <= '0;
            cache_cea_q     <= 1'b0;
            cache_we_q      <= 1'b0;
            cache_wdata_q   <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            hit_q           <= hit_d;
            miss_q          <= miss_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            cache_addra_q   <= cache_addra_d;
            cache_cea_q     <= cache_cea_d;
            cache_we_q      <= cache_we_d;
            cache_wdata_q   <= cache_wdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = resp_data_q;
    assign cache_addra_o   = cache_addra_q;
    assign cache_cea_o     = cache_cea_q;
    assign cache_we_o      = cache_we_q;
    assign cache_wdata_o   = cache_wdata_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_req_addr_q;
    assign hit_count_o     = hit_q;
    assign miss_count_o    = miss_q;

    // Memory may not answer in the cycle its request is accepted.
    a_no_early_resp: assert property (
        @(posedge clk) disable iff (reset)
        !(mem_req_valid_o && mem_req_ready_i && mem_resp_valid_i)
    );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl paired with a behavioural dual-port cache and memory.
module tb_cache_fill_ctrl;
    import cache_ctrl_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [DW-1:0] resp_data_o;
    logic [AW-1:0] cache_addra_o;
    logic          cache_cea_o;
    logic          cache_we_o;
    logic [DW-1:0] cache_wdata_o;
    logic [DW-1:0] cache_rdataa_i;
    logic          cache_rhita_i;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i = 1'b0;
    logic [AW-1:0] mem_req_addr_o;
    logic          mem_resp_valid_i = 1'b0;
    logic [DW-1:0] mem_resp_data_i = '0;
    logic [CW-1:0] hit_count_o;
    logic [CW-1:0] miss_count_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl #(
        .IDX_BITS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o),
        .cache_addra_o(cache_addra_o), .cache_cea_o(cache_cea_o),
        .cache_we_o(cache_we_o), .cache_wdata_o(cache_wdata_o),
        .cache_rdataa_i(cache_rdataa_i), .cache_rhita_i(cache_rhita_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dual-port tagged direct-mapped cache, port A only; cleared by reset.
    logic          c_valid [4] = '{default: 1'b0};
    logic [5:0]    c_tag   [4];
    logic [DW-1:0] c_data  [4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) c_valid[i] <= 1'b0;
        end else if (cache_cea_o && cache_we_o) begin
            c_valid[get_idx(cache_addra_o)] <= 1'b1;
            c_tag[get_idx(cache_addra_o)]   <= get_tag(cache_addra_o);
            c_data[get_idx(cache_addra_o)]  <= cache_wdata_o;
        end
    end

    assign cache_rhita_i = cache_cea_o && c_valid[get_idx(cache_addra_o)]
                           && (c_tag[get_idx(cache_addra_o)] == get_tag(cache_addra_o));
    assign cache_rdataa_i = cache_cea_o ? c_data[get_idx(cache_addra_o)] : '0;

    // Backing memory: optional accept stall, data one idle cycle after accept.
    logic [DW-1:0] mem_arr [256];
    int            mem_stall_cfg = 0;
    int            stall_left = 0;
    int            pend = 0;
    int            mem_hs_cnt = 0;
    int            stray_cnt = 0;
    int            stray_done = 0;
    bit            waiting = 0;
    logic [AW-1:0] pend_addr;
    logic [AW-1:0] held_addr;
    logic [AW-1:0] last_mem_addr;

    always @(negedge clk) begin
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        if (reset) begin
            pend = 0;
            waiting = 0;
            mem_req_ready_i = 1'b0;
        end else begin
            if (stray_done != stray_cnt) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = 16'hDEAD;
                stray_done = stray_cnt;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_resp_valid_i = 1'b1;
                    mem_resp_data_i  = mem_arr[pend_addr];
                end
            end
            if (mem_req_valid_o) begin
                if (!waiting) begin
                    waiting    = 1;
                    stall_left = mem_stall_cfg;
                    held_addr  = mem_req_addr_o;
                end else begin
                    check("mem_addr_stable", mem_req_addr_o, held_addr);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    mem_req_ready_i = 1'b0;
                end else begin
                    mem_req_ready_i = 1'b1;
                    mem_hs_cnt++;
                    last_mem_addr = mem_req_addr_o;
                    pend_addr = mem_req_addr_o;
                    pend = 2;
                    waiting = 0;
                end
            end else begin
                if (waiting) check("mem_valid_held", 0, 1);
                waiting = 0;
                mem_req_ready_i = 1'b0;
            end
        end
    end

    // Cache write monitor.
    int            we_cnt = 0;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;

    always @(negedge clk) begin
        if (cache_we_o) begin
            we_cnt++;
            we_addr = cache_addra_o;
            we_data = cache_wdata_o;
        end
    end

    // Reference: which address each index currently holds, plus counters.
    bit            res_v [4];
    logic [AW-1:0] res_a [4];
    int            exp_hits = 0;
    int            exp_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) res_v[i] = 0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_req(input logic [AW-1:0] a, input int rstall,
                          input int mstall);
        bit exp_hit;
        int we0, hs0, cyc, lat;
        logic [DW-1:0] d0;
        exp_hit = res_v[get_idx(a)] && (res_a[get_idx(a)] == a);
        we0 = we_cnt;
        hs0 = mem_hs_cnt;
        mem_stall_cfg = mstall;
        check("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        check("req_ready_busy", req_ready_o, 0);
        cyc = 1;
        while (!resp_valid_o && cyc < 60) begin
            tick();
            cyc++;
        end
        lat = exp_hit ? 2 : 6 + mstall;
        check("latency", cyc, lat);
        check("resp_data", resp_data_o, mem_arr[a]);
        d0 = resp_data_o;
        for (int s = 0; s < rstall; s++) begin
            tick();
            check("resp_valid_hold", resp_valid_o, 1);
            check("resp_data_hold", resp_data_o, d0);
            check("req_ready_hold", req_ready_o, 0);
        end
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("resp_done", resp_valid_o, 0);
        check("req_ready_back", req_ready_o, 1);
        if (exp_hit) exp_hits++;
        else exp_misses++;
        res_v[get_idx(a)] = 1;
        res_a[get_idx(a)] = a;
        check("we_pulses", we_cnt - we0, exp_hit ? 0 : 1);
        check("mem_reqs", mem_hs_cnt - hs0, exp_hit ? 0 : 1);
        if (!exp_hit) begin
            check("fill_addr", we_addr, a);
            check("fill_data", we_data, mem_arr[a]);
            check("mem_addr", last_mem_addr, a);
        end
        check("hit_count", hit_count_o, exp_hits);
        check("miss_count", miss_count_o, exp_misses);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int hs0, we0, guard;
        logic [AW-1:0] ra;

        reset = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 256; i++) mem_arr[i] = DW'($urandom);
        mem_arr[8'h15] = 16'hBEEF;
        mem_arr[8'h25] = 16'h1234;
        model_reset();

        // Reset held three cycles.
        repeat (3) tick();
        check("rst_req_ready_held", req_ready_o, 1);
        reset = 1'b0;
        tick();
        check("rst_req_ready", req_ready_o, 1);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_resp_data", resp_data_o, 0);
        check("rst_cache_addr", cache_addra_o, 0);
        check("rst_cache_cea", cache_cea_o, 0);
        check("rst_cache_we", cache_we_o, 0);
        check("rst_cache_wdata", cache_wdata_o, 0);
        check("rst_mem_valid", mem_req_valid_o, 0);
        check("rst_mem_addr", mem_req_addr_o, 0);
        check("rst_hits", hit_count_o, 0);
        check("rst_misses", miss_count_o, 0);

        // Cold miss, repeat hit, conflict refetches.
        do_req(8'h15, 0, 0);
        do_req(8'h15, 0, 0);
        do_req(8'h25, 0, 0);
        do_req(8'h15, 0, 0);
        check("miss_count_3", miss_count_o, 3);

        // Response back-pressure on a hit, then a stalled memory.
        do_req(8'h15, 4, 0);
        do_req(8'h35, 0, 5);

        // Randomized traffic over a small address pool.
        for (int n = 0; n < 40; n++) begin
            ra = AW'($urandom_range(0, 15));
            do_req(ra, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while waiting on memory.
        mem_stall_cfg = 0;
        hs0 = mem_hs_cnt;
        req_valid_i = 1'b1;
        req_addr_i = 8'h3A;
        tick();
        req_valid_i = 1'b0;
        guard = 0;
        while (mem_hs_cnt == hs0 && guard < 20) begin
            tick();
            guard++;
        end
        check("rst_mid_reached", mem_hs_cnt - hs0, 1);
        tick();
        we0 = we_cnt;
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_req_ready", req_ready_o, 1);
        check("mid_rst_resp_valid", resp_valid_o, 0);
        check("mid_rst_mem_valid", mem_req_valid_o, 0);
        check("mid_rst_cea", cache_cea_o, 0);
        check("mid_rst_we", cache_we_o, 0);
        check("mid_rst_misses", miss_count_o, 0);
        tick();
        tick();
        reset = 1'b0;
        stray_cnt++;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stray_idle", req_ready_o, 1);
            check("stray_no_resp", resp_valid_o, 0);
        end
        check("stray_sent", stray_done, stray_cnt);
        check("no_fill_after_rst", we_cnt - we0, 0);
        do_req(8'h15, 0, 0);
        check("post_rst_miss", miss_count_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
